ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage of the 5-stage MIPS pipeline; consumes ALU control output (aluc, sftmd, jr, jalr).
//  Holds the ID/EX register, computes the ALU result and registers it into EX/MEM.
//  Raises a one-shot jr/jalr redirect to IF and supports hazard-unit stall and flush.
// PARAMETERS
//  DW      32  datapath width
//  RESET_PC 0  value loaded into ex_pc/mem_pc on reset
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   synchronous, active-high reset
//  id_valid     in   1   ID slot holds a real instruction
//  id_pc        in   DW  PC of ID instruction
//  id_rs, id_rt in   DW  register operands (already forwarded)
//  id_imm       in   DW  extended immediate
//  id_shamt     in   5   instr[10:6]
//  id_aluc      in   5   ALU op code (encoding below)
//  id_sftmd     in   1   1: shift amount from shamt, 0: from rs[4:0]
//  id_jr,id_jalr in  1   register-jump flags (R-type qualified)
//  id_alusrc    in   1   1: operand B = imm, 0: rt
//  id_rd        in   5   destination register
//  id_regwr,id_memrd,id_memwr in 1 control bits
//  stall        in   1   hold ID/EX, bubble into EX/MEM
//  flush        in   1   kill ID/EX contents
//  mem_valid    out  1   EX/MEM slot valid
//  mem_result   out  DW  registered ALU result
//  mem_rt       out  DW  store data
//  mem_rd       out  5   destination register
//  mem_regwr,mem_memrd,mem_memwr out 1  registered control (0 when !mem_valid)
//  redirect     out  1   jr/jalr target valid (combinational, one-shot)
//  redirect_pc  out  DW  target = ID/EX rs value
// BEHAVIOUR
//  Reset: ID/EX and EX/MEM valid=0, all data/control regs 0, PCs=RESET_PC, fired flag 0.
//  Latency: ID→result at mem_* is 2 edges (ID/EX capture, EX/MEM capture).
//  ID/EX update each edge: flush -> valid=0 (flush wins over stall); else stall -> hold; else load id_*.
//  EX/MEM update: stall -> mem_valid=0, controls 0 (bubble); else load EX result and controls, valid=ex_valid.
//  Stall and flush together: ID/EX cleared, EX/MEM bubble.
//  Operands: A=rs, B=alusrc?imm:rt; shift amount sa = sftmd?shamt:rs[4:0]; shifts act on rt.
//  aluc: 0 addu A+B mod 2^32; 1 subu A-B; 2 slt signed A<B ->1/0; 3 and; 4 nor; 5 or; 6 xor;
//        7 sll; 8 srl; 9 sltu unsigned; 10 jalr result=pc+8; 11 jr result=0; 12 sllv; 13 sra;
//        14 srav; 15 srlv; 16-31 result 0 and regwr forced 0. No overflow traps.
//  sllv/srlv/srav codes use rs[4:0] regardless of sftmd; sra/srav sign-fill from rt[31].
//  jr: regwr forced 0. jalr: writes pc+8 to rd.
//  redirect = ex_valid & (jr|jalr) & !fired; fired set when redirect asserted and stall=1,
//    cleared when ID/EX loads/flushes. Exactly one redirect pulse per jump even under stall.
//  Flush same cycle as redirect: redirect still asserted that cycle.
//  Non-valid EX slot: all mem_* controls 0, result don't-care (drive 0).
// TESTING
//  addu: rs=0xFFFFFFFF, rt=2, aluc=0 -> 2 edges later mem_result=1, mem_regwr=1.
//  slt vs sltu: rs=0xFFFFFFFE, rt=1 -> aluc2 result 1, aluc9 result 0.
//  sra shamt=4, rt=0x80000000, sftmd=1 -> 0xF8000000; srlv rs=4 -> 0x08000000.
//  jalr pc=0x100, rs=0x400, stall 3 cycles -> redirect high exactly 1 cycle, pc=0x400; result 0x108.
//  stall+flush same edge with valid addu in ID/EX -> next cycle mem_valid=0, ex slot empty.
//  rst asserted mid-stream with 2 valid instructions -> next edge all outputs 0, no redirect.

Source files
------------

// File: rtl/ex_if.sv
// ex_if: ID-side inputs, hazard controls and EX/MEM outputs of the execute stage
interface ex_if #(parameter int DW = 32);
  logic          id_valid;
  logic [DW-1:0] id_pc;
  logic [DW-1:0] id_rs;
  logic [DW-1:0] id_rt;
  logic [DW-1:0] id_imm;
  logic [4:0]    id_shamt;
  logic [4:0]    id_aluc;
  logic          id_sftmd;
  logic          id_jr;
  logic          id_jalr;
  logic          id_alusrc;
  logic [4:0]    id_rd;
  logic          id_regwr;
  logic          id_memrd;
  logic          id_memwr;
  logic          stall;
  logic          flush;
  logic          mem_valid;
  logic [DW-1:0] mem_pc;
  logic [DW-1:0] mem_result;
  logic [DW-1:0] mem_rt;
  logic [4:0]    mem_rd;
  logic          mem_regwr;
  logic          mem_memrd;
  logic          mem_memwr;
  logic          redirect;
  logic [DW-1:0] redirect_pc;
  modport slave (
    input  id_valid, id_pc, id_rs, id_rt, id_imm, id_shamt, id_aluc, id_sftmd,
           id_jr, id_jalr, id_alusrc, id_rd, id_regwr, id_memrd, id_memwr, stall, flush,
    output mem_valid, mem_pc, mem_result, mem_rt, mem_rd, mem_regwr, mem_memrd, mem_memwr,
           redirect, redirect_pc
  );
  modport master (
    output id_valid, id_pc, id_rs, id_rt, id_imm, id_shamt, id_aluc, id_sftmd,
           id_jr, id_jalr, id_alusrc, id_rd, id_regwr, id_memrd, id_memwr, stall, flush,
    input  mem_valid, mem_pc, mem_result, mem_rt, mem_rd, mem_regwr, mem_memrd, mem_memwr,
           redirect, redirect_pc
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with ID/EX and EX/MEM registers, ALU and one-shot jr/jalr redirect
module ex_stage #(
  parameter int            DW       = 32,
  parameter logic [DW-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  ex_if.slave bus
);
  logic          ex_valid;
  logic [DW-1:0] ex_pc;
  logic [DW-1:0] ex_rs;
  logic [DW-1:0] ex_rt;
  logic [DW-1:0] ex_imm;
  logic [4:0]    ex_shamt;
  logic [4:0]    ex_aluc;
  logic          ex_sftmd;
  logic          ex_jr;
  logic          ex_jalr;
  logic          ex_alusrc;
  logic [4:0]    ex_rd;
  logic          ex_regwr;
  logic          ex_memrd;
  logic          ex_memwr;
  logic          fired;
  logic [DW-1:0] b;
  logic [DW-1:0] res;
  logic [4:0]    sa;
  logic          wr_ok;
  logic          go;

  assign b     = ex_alusrc ? ex_imm : ex_rt;
  assign sa    = ex_sftmd ? ex_shamt : ex_rs[4:0];
  assign wr_ok = !ex_jr && !ex_aluc[4] && ex_aluc != 5'd11;
  assign go    = ex_valid && !bus.stall;

  // redirect stays a single pulse per jump: fired remembers one already issued while stalled
  assign bus.redirect    = ex_valid && (ex_jr || ex_jalr) && !fired;
  assign bus.redirect_pc = ex_rs;

  // ALU result for the instruction sitting in ID/EX; shifts always operate on rt
  always_comb begin
    res = '0;
    case (ex_aluc)
      5'd0:  res = ex_rs + b;
      5'd1:  res = ex_rs - b;
      5'd2:  res = {{(DW-1){1'b0}}, $signed(ex_rs) < $signed(b)};
      5'd3:  res = ex_rs & b;
      5'd4:  res = ~(ex_rs | b);
      5'd5:  res = ex_rs | b;
      5'd6:  res = ex_rs ^ b;
      5'd7:  res = ex_rt << sa;
      5'd8:  res = ex_rt >> sa;
      5'd9:  res = {{(DW-1){1'b0}}, ex_rs < b};
      5'd10: res = ex_pc + DW'(8);
      5'd12: res = ex_rt << ex_rs[4:0];
      5'd13: res = $signed(ex_rt) >>> sa;
      5'd14: res = $signed(ex_rt) >>> ex_rs[4:0];
      5'd15: res = ex_rt >> ex_rs[4:0];
      default: res = '0;
    endcase
  end

  // ID/EX register: flush beats stall, stall holds, otherwise capture the ID slot
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_pc     <= RESET_PC;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_imm    <= '0;
      ex_shamt  <= '0;
      ex_aluc   <= '0;
      ex_sftmd  <= 1'b0;
      ex_jr     <= 1'b0;
      ex_jalr   <= 1'b0;
      ex_alusrc <= 1'b0;
      ex_rd     <= '0;
      ex_regwr  <= 1'b0;
      ex_memrd  <= 1'b0;
      ex_memwr  <= 1'b0;
      fired     <= 1'b0;
    end else if (bus.flush) begin
      ex_valid <= 1'b0;
      fired    <= 1'b0;
    end else if (bus.stall) begin
      fired <= fired || bus.redirect;
    end else begin
      ex_valid  <= bus.id_valid;
      ex_pc     <= bus.id_pc;
      ex_rs     <= bus.id_rs;
      ex_rt     <= bus.id_rt;
      ex_imm    <= bus.id_imm;
      ex_shamt  <= bus.id_shamt;
      ex_aluc   <= bus.id_aluc;
      ex_sftmd  <= bus.id_sftmd;
      ex_jr     <= bus.id_jr;
      ex_jalr   <= bus.id_jalr;
      ex_alusrc <= bus.id_alusrc;
      ex_rd     <= bus.id_rd;
      ex_regwr  <= bus.id_regwr;
      ex_memrd  <= bus.id_memrd;
      ex_memwr  <= bus.id_memwr;
      fired     <= 1'b0;
    end
  end

  // EX/MEM register: a stall or empty EX slot produces an all-zero bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_valid  <= 1'b0;
      bus.mem_pc     <= RESET_PC;
      bus.mem_result <= '0;
      bus.mem_rt     <= '0;
      bus.mem_rd     <= '0;
      bus.mem_regwr  <= 1'b0;
      bus.mem_memrd  <= 1'b0;
      bus.mem_memwr  <= 1'b0;
    end else begin
      bus.mem_valid  <= go;
      bus.mem_pc     <= go ? ex_pc : bus.mem_pc;
      bus.mem_result <= go ? res : '0;
      bus.mem_rt     <= go ? ex_rt : '0;
      bus.mem_rd     <= go ? ex_rd : '0;
      bus.mem_regwr  <= go && ex_regwr && wr_ok;
      bus.mem_memrd  <= go && ex_memrd;
      bus.mem_memwr  <= go && ex_memwr;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed scoreboard bench for the execute stage
module tb_ex_stage;
  typedef struct {
    logic [31:0] res;
    logic [31:0] rt;
    logic [4:0]  rd;
    logic        regwr;
    logic        memrd;
    logic        memwr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int n_tests = 0;
  int n_fail = 0;
  int n_redir = 0;
  logic [4:0] rd_ctr = 5'd1;
  exp_t q[$];

  ex_if #(.DW(32)) bus ();
  ex_stage #(.DW(32), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.id_valid = 1'b0;
    bus.id_jr = 1'b0;
    bus.id_jalr = 1'b0;
  endtask

  task automatic op(input logic [4:0] aluc, input logic [31:0] rs, input logic [31:0] rt,
                    input logic [31:0] imm, input logic [4:0] shamt, input logic sftmd,
                    input logic alusrc);
    bus.id_valid = 1'b1;
    bus.id_pc = 32'h1000 + {27'd0, rd_ctr} * 4;
    bus.id_aluc = aluc;
    bus.id_rs = rs;
    bus.id_rt = rt;
    bus.id_imm = imm;
    bus.id_shamt = shamt;
    bus.id_sftmd = sftmd;
    bus.id_alusrc = alusrc;
    bus.id_jr = 1'b0;
    bus.id_jalr = 1'b0;
    bus.id_regwr = 1'b1;
    bus.id_memrd = 1'b0;
    bus.id_memwr = 1'b0;
    bus.id_rd = rd_ctr;
    rd_ctr++;
  endtask

  task automatic push(input logic [31:0] res, input logic regwr);
    q.push_back('{res, bus.id_rt, bus.id_rd, regwr, bus.id_memrd, bus.id_memwr});
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.redirect) n_redir++;
    if (bus.mem_valid) begin
      if (q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        check("result", bus.mem_result, e.res);
        check("rt", bus.mem_rt, e.rt);
        check("rd", {27'd0, bus.mem_rd}, {27'd0, e.rd});
        check("regwr", {31'd0, bus.mem_regwr}, {31'd0, e.regwr});
        check("memrd", {31'd0, bus.mem_memrd}, {31'd0, e.memrd});
        check("memwr", {31'd0, bus.mem_memwr}, {31'd0, e.memwr});
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    op(5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    idle();
    tick();
    tick();
    check("rst_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("rst_result", bus.mem_result, 32'd0);
    check("rst_regwr", {31'd0, bus.mem_regwr}, 32'd0);
    check("rst_redirect", {31'd0, bus.redirect}, 32'd0);
    rst = 1'b0;
    // back-to-back ALU stream
    op(5'd0, 32'hFFFFFFFF, 32'd2, 32'd0, 5'd0, 1'b0, 1'b0); push(32'd1, 1'b1); tick();
    op(5'd1, 32'd5, 32'd7, 32'd0, 5'd0, 1'b0, 1'b0); push(32'hFFFFFFFE, 1'b1); tick();
    op(5'd2, 32'hFFFFFFFE, 32'd1, 32'd0, 5'd0, 1'b0, 1'b0); push(32'd1, 1'b1); tick();
    op(5'd9, 32'hFFFFFFFE, 32'd1, 32'd0, 5'd0, 1'b0, 1'b0); push(32'd0, 1'b1); tick();
    op(5'd3, 32'hF0F0F0F0, 32'd0, 32'h0FF00FF0, 5'd0, 1'b0, 1'b1); push(32'h00F000F0, 1'b1); tick();
    op(5'd4, 32'hF0F0F0F0, 32'h0F0F0000, 32'd0, 5'd0, 1'b0, 1'b0); push(32'h00000F0F, 1'b1); tick();
    op(5'd5, 32'h12340000, 32'h00005678, 32'd0, 5'd0, 1'b0, 1'b0); push(32'h12345678, 1'b1); tick();
    op(5'd6, 32'hFFFF0000, 32'h0F0F0F0F, 32'd0, 5'd0, 1'b0, 1'b0); push(32'hF0F00F0F, 1'b1); tick();
    op(5'd7, 32'd0, 32'h000000AB, 32'd0, 5'd8, 1'b1, 1'b0); push(32'h0000AB00, 1'b1); tick();
    op(5'd8, 32'd4, 32'h000000F0, 32'd0, 5'd9, 1'b0, 1'b0); push(32'h0000000F, 1'b1); tick();
    op(5'd13, 32'd0, 32'h80000000, 32'd0, 5'd4, 1'b1, 1'b0); push(32'hF8000000, 1'b1); tick();
    op(5'd15, 32'd4, 32'h80000000, 32'd0, 5'd8, 1'b1, 1'b0); push(32'h08000000, 1'b1); tick();
    op(5'd12, 32'h24, 32'd1, 32'd0, 5'd1, 1'b1, 1'b0); push(32'h10, 1'b1); tick();
    op(5'd14, 32'h1F, 32'h80000000, 32'd0, 5'd0, 1'b1, 1'b0); push(32'hFFFFFFFF, 1'b1); tick();
    op(5'd20, 32'd5, 32'd6, 32'd0, 5'd0, 1'b0, 1'b0); push(32'd0, 1'b0); tick();
    op(5'd0, 32'h100, 32'hDEADBEEF, 32'd4, 5'd0, 1'b0, 1'b1);
    bus.id_regwr = 1'b0; bus.id_memwr = 1'b1; push(32'h104, 1'b0); tick();
    op(5'd0, 32'h200, 32'd0, 32'd8, 5'd0, 1'b0, 1'b1);
    bus.id_memrd = 1'b1; push(32'h208, 1'b1); tick();
    op(5'd11, 32'h200, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    bus.id_jr = 1'b1; push(32'd0, 1'b0); tick();
    check("jr_redirect", {31'd0, bus.redirect}, 32'd1);
    check("jr_target", bus.redirect_pc, 32'h200);
    op(5'd5, 32'd1, 32'd2, 32'd0, 5'd0, 1'b0, 1'b0); push(32'd3, 1'b1); tick();
    check("jr_oneshot", {31'd0, bus.redirect}, 32'd0);
    idle(); tick(); tick();
    // jalr held by a 3-cycle stall
    op(5'd10, 32'h400, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    bus.id_jalr = 1'b1; bus.id_pc = 32'h100; bus.id_rd = 5'd31; push(32'h108, 1'b1);
    n_redir = 0;
    tick();
    check("jalr_redirect", {31'd0, bus.redirect}, 32'd1);
    check("jalr_target", bus.redirect_pc, 32'h400);
    idle();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_bubble", {31'd0, bus.mem_valid}, 32'd0);
    end
    bus.stall = 1'b0;
    tick();
    check("jalr_pulses", n_redir, 32'd1);
    // stall and flush on the same edge
    op(5'd0, 32'd1, 32'd1, 32'd0, 5'd0, 1'b0, 1'b0); tick();
    idle(); bus.stall = 1'b1; bus.flush = 1'b1; tick();
    check("sf_bubble", {31'd0, bus.mem_valid}, 32'd0);
    bus.stall = 1'b0; bus.flush = 1'b0; tick();
    check("sf_empty", {31'd0, bus.mem_valid}, 32'd0);
    // flush in the same cycle as a redirect
    op(5'd11, 32'h300, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    bus.id_jr = 1'b1; push(32'd0, 1'b0); tick();
    idle(); bus.flush = 1'b1; #1;
    check("flush_redirect", {31'd0, bus.redirect}, 32'd1);
    check("flush_target", bus.redirect_pc, 32'h300);
    tick();
    check("flush_after", {31'd0, bus.redirect}, 32'd0);
    bus.flush = 1'b0;
    // reset with two instructions in flight
    op(5'd0, 32'hFFFFFFFF, 32'd2, 32'd0, 5'd0, 1'b0, 1'b0); push(32'd1, 1'b1); tick();
    op(5'd10, 32'h500, 32'd7, 32'd0, 5'd0, 1'b0, 1'b0); bus.id_jalr = 1'b1; tick();
    check("pre_rst_redirect", {31'd0, bus.redirect}, 32'd1);
    rst = 1'b1; idle(); tick();
    check("mrst_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("mrst_result", bus.mem_result, 32'd0);
    check("mrst_rt", bus.mem_rt, 32'd0);
    check("mrst_rd", {27'd0, bus.mem_rd}, 32'd0);
    check("mrst_ctl", {29'd0, bus.mem_regwr, bus.mem_memrd, bus.mem_memwr}, 32'd0);
    check("mrst_redirect", {31'd0, bus.redirect}, 32'd0);
    check("mrst_target", bus.redirect_pc, 32'd0);
    rst = 1'b0; tick();
    check("post_rst_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("queue_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
